// File: rtl/uart_boot_loader_ctrl.sv
// UART boot loader controller: parses a framed byte stream (sync, word
// count, little-endian data words, additive checksum), writes the words
// into instruction memory, replies ACK/NAK and then releases the core.
module uart_boot_loader_ctrl #(
    parameter int          ADDR_W      = 8,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [7:0]  ACK_BYTE    = 8'h4B,
    parameter logic [7:0]  NAK_BYTE    = 8'h45,
    parameter int          TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic              boot_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              loading,
    output logic              load_err
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

    // SEND is split into the request cycle and the two phases of watching
    // the transmitter's busy flag go high and then low again.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COUNT   = 3'd1,
        ST_DATA    = 3'd2,
        ST_CSUM    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_HI = 3'd5,
        ST_WAIT_LO = 3'd6,
        ST_RUN     = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          count_q, count_d;        // N words in this frame
    logic [7:0]          word_cnt_q, word_cnt_d;  // words written so far
    logic [ADDR_W-1:0]   word_idx_q, word_idx_d;  // next imem word address
    logic [1:0]          lane_q, lane_d;          // byte lane inside the word
    logic [31:0]         word_buf_q, word_buf_d;
    logic [7:0]          csum_q, csum_d;
    logic                is_ack_q, is_ack_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]         imem_wdata_q, imem_wdata_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                loading_q, loading_d;
    logic                load_err_q, load_err_d;
    logic                in_frame_s;
    logic                timed_out_s;

    assign in_frame_s  = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign timed_out_s = (timer_q == TMR_LAST);

    // Next-state, datapath and output computation for the loader FSM.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_cnt_d   = word_cnt_q;
        word_idx_d   = word_idx_q;
        lane_d       = lane_q;
        word_buf_d   = word_buf_q;
        csum_d       = csum_q;
        is_ack_d     = is_ack_q;
        timer_d      = timer_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        loading_d    = loading_q;
        load_err_d   = load_err_q;
        cpu_rst_n_d  = 1'b0;

        if (boot_req) begin
            // Abort wins over any byte arriving this cycle; a running
            // transmission simply finishes on its own.
            state_d   = ST_IDLE;
            loading_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        word_idx_d = '0;
                        word_cnt_d = 8'd0;
                        lane_d     = 2'd0;
                        csum_d     = 8'd0;
                        load_err_d = 1'b0;
                        loading_d  = 1'b1;
                        state_d    = ST_COUNT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (rx_valid) begin
                        count_d = rx_data;
                        state_d = (rx_data == 8'd0) ? ST_CSUM : ST_DATA;
                    end else if (timed_out_s) begin
                        load_err_d = 1'b1;
                        is_ack_d   = 1'b0;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_COUNT;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        csum_d = csum_q + rx_data;
                        lane_d = lane_q + 2'd1;
                        case (lane_q)
                            2'd0:    word_buf_d[7:0]   = rx_data;
                            2'd1:    word_buf_d[15:8]  = rx_data;
                            2'd2:    word_buf_d[23:16] = rx_data;
                            default: word_buf_d[31:24] = rx_data;
                        endcase
                        if (lane_q == 2'd3) begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_idx_q;
                            imem_wdata_d = {rx_data, word_buf_q[23:0]};
                            word_idx_d   = word_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            word_cnt_d   = word_cnt_q + 8'd1;
                            state_d      = (word_cnt_q == (count_q - 8'd1)) ? ST_CSUM : ST_DATA;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else if (timed_out_s) begin
                        load_err_d = 1'b1;
                        is_ack_d   = 1'b0;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            is_ack_d = 1'b1;
                        end else begin
                            is_ack_d   = 1'b0;
                            load_err_d = 1'b1;
                        end
                        state_d = ST_SEND;
                    end else if (timed_out_s) begin
                        load_err_d = 1'b1;
                        is_ack_d   = 1'b0;
                        state_d    = ST_SEND;
                    end else begin
                        state_d = ST_CSUM;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = is_ack_q ? ACK_BYTE : NAK_BYTE;
                        loading_d  = 1'b0;
                        state_d    = ST_WAIT_HI;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
                ST_WAIT_HI: begin
                    if (tx_busy) begin
                        state_d = ST_WAIT_LO;
                    end else begin
                        state_d = ST_WAIT_HI;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_busy) begin
                        state_d = is_ack_q ? ST_RUN : ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_LO;
                    end
                end
                ST_RUN: begin
                    // The core owns the UART now; incoming bytes are ignored.
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Inter-byte timer restarts on every byte and on every state change.
        if (rx_valid || (state_d != state_q)) begin
            timer_d = '0;
        end else if (in_frame_s) begin
            timer_d = timer_q + TMR_ONE;
        end else begin
            timer_d = '0;
        end

        // Core leaves reset exactly while the FSM sits in RUN.
        if (state_d == ST_RUN) begin
            cpu_rst_n_d = 1'b1;
        end else begin
            cpu_rst_n_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= 8'd0;
            word_cnt_q   <= 8'd0;
            word_idx_q   <= '0;
            lane_q       <= 2'd0;
            word_buf_q   <= 32'd0;
            csum_q       <= 8'd0;
            is_ack_q     <= 1'b0;
            timer_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'd0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'd0;
            cpu_rst_n_q  <= 1'b0;
            loading_q    <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            word_cnt_q   <= word_cnt_d;
            word_idx_q   <= word_idx_d;
            lane_q       <= lane_d;
            word_buf_q   <= word_buf_d;
            csum_q       <= csum_d;
            is_ack_q     <= is_ack_d;
            timer_q      <= timer_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            loading_q    <= loading_d;
            load_err_q   <= load_err_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_rst_n  = cpu_rst_n_q;
    assign loading    = loading_q;
    assign load_err   = load_err_q;

endmodule
